// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer game: FSM state encoding and
// reset constants reused by the counter and display blocks.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    TIMING  = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [7:0] BEST_INIT = 8'h99;
  localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used to randomise
// the pre-stimulus wait.
module lfsr8
  import reaction_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  output logic [7:0] q
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) q <= LFSR_SEED;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-timer stimulus/scoring controller: random wait, w pulse, false
// start and timeout detection, and a packed-BCD best-time register.
module reaction_stimulus
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY = 16,
  parameter int RAND_BITS = 6,
  parameter int TIMEOUT   = 200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       Start,
  input  logic       Pushn,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  output logic       w,
  output logic       Busy,
  output logic       FalseStart,
  output logic       TimedOut,
  output logic       NewBest,
  output logic [3:0] Best1,
  output logic [3:0] Best0
);

  state_t     state, nextState;
  logic [8:0] dcnt, dcntNext;
  logic [7:0] tcnt, tcntNext;
  logic [7:0] best, bestNext;
  logic [7:0] lfsr;
  logic [7:0] sample;
  logic       wNext, busyNext, falseNext, timedNext, newBestNext;
  logic       unusedLfsr;

  lfsr8 u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .q     (lfsr)
  );

  assign unusedLfsr = ^lfsr;
  assign sample     = {BCD1, BCD0};
  assign Best1      = best[7:4];
  assign Best0      = best[3:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      dcnt       <= '0;
      tcnt       <= '0;
      best       <= BEST_INIT;
      w          <= 1'b0;
      Busy       <= 1'b0;
      FalseStart <= 1'b0;
      TimedOut   <= 1'b0;
      NewBest    <= 1'b0;
    end else begin
      state      <= nextState;
      dcnt       <= dcntNext;
      tcnt       <= tcntNext;
      best       <= bestNext;
      w          <= wNext;
      Busy       <= busyNext;
      FalseStart <= falseNext;
      TimedOut   <= timedNext;
      NewBest    <= newBestNext;
    end
  end

  // Every output is the registered image of its next value, so nothing
  // here reaches a port without passing through a flop.
  always_comb begin
    nextState   = state;
    dcntNext    = dcnt;
    tcntNext    = tcnt;
    bestNext    = best;
    wNext       = 1'b0;
    newBestNext = 1'b0;
    falseNext   = FalseStart;
    timedNext   = TimedOut;

    case (state)
      IDLE: begin
        if (Start && Pushn) begin
          dcntNext  = 9'(MIN_DELAY) + 9'(lfsr[RAND_BITS-1:0]);
          falseNext = 1'b0;
          timedNext = 1'b0;
          nextState = DELAY;
        end
      end
      DELAY: begin
        if (!Pushn) begin
          falseNext = 1'b1;
          nextState = IDLE;
        end else if (tick) begin
          if (dcnt == '0) begin
            wNext     = 1'b1;
            tcntNext  = 8'(TIMEOUT);
            nextState = TIMING;
          end else begin
            dcntNext = dcnt - 9'd1;
          end
        end
      end
      TIMING: begin
        if (!Pushn) begin
          nextState = CAPTURE;
        end else if (tick) begin
          if (tcnt == '0) begin
            timedNext = 1'b1;
            nextState = IDLE;
          end else begin
            tcntNext = tcnt - 8'd1;
          end
        end
      end
      CAPTURE: begin
        // Packed BCD orders numerically, so a plain unsigned compare works.
        if (tick) begin
          if (sample < best) begin
            bestNext    = sample;
            newBestNext = 1'b1;
          end
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    busyNext = (nextState != IDLE);
  end

endmodule

// File: tb/tb_reaction_stimulus.sv
// Directed bench for reaction_stimulus with a reference LFSR and queues of
// expected w delays and best-time results.
`timescale 1ns/1ps
module tb_reaction_stimulus;

  localparam int MIN_DELAY = 16;
  localparam int RAND_BITS = 6;
  localparam int TIMEOUT   = 5;

  typedef struct {
    logic [7:0] best;
    logic       newBest;
  } best_exp_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       tick  = 1'b0;
  logic       Start = 1'b0;
  logic       Pushn = 1'b1;
  logic [3:0] BCD1  = 4'd0;
  logic [3:0] BCD0  = 4'd0;
  logic       w, Busy, FalseStart, TimedOut, NewBest;
  logic [3:0] Best1, Best0;

  int         checks = 0;
  int         failures = 0;
  int         tickCount = 0;
  int         wCount = 0;
  int         startTick = 0;
  int         wTick = 0;
  logic [7:0] modelLfsr;
  int         delayQ[$];
  best_exp_t  bestQ[$];

  reaction_stimulus #(
    .MIN_DELAY (MIN_DELAY),
    .RAND_BITS (RAND_BITS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .tick       (tick),
    .Start      (Start),
    .Pushn      (Pushn),
    .BCD1       (BCD1),
    .BCD0       (BCD0),
    .w          (w),
    .Busy       (Busy),
    .FalseStart (FalseStart),
    .TimedOut   (TimedOut),
    .NewBest    (NewBest),
    .Best1      (Best1),
    .Best0      (Best0)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) tick = ~tick;

  always @(posedge Clock) if (tick) tickCount++;

  always @(negedge Clock) if (w === 1'b1) wCount++;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) modelLfsr <= 8'h01;
    else       modelLfsr <= {modelLfsr[6:0], modelLfsr[7] ^ modelLfsr[5] ^ modelLfsr[4] ^ modelLfsr[3]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_w"}, 32'(w), 32'd0);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_flags"}, 32'({FalseStart, TimedOut, NewBest}), 32'd0);
    checkOutput({tag, "_best"}, 32'({Best1, Best0}), 32'h99);
  endtask

  // forcedDelay=0 derives the expected wait from the reference LFSR.
  task automatic applyStimulus(input bit expectW, input int forcedDelay);
    @(negedge Clock);
    Start = 1'b1;
    if (expectW)
      delayQ.push_back(forcedDelay != 0 ? forcedDelay
                                        : MIN_DELAY + int'(modelLfsr & 8'h3F) + 1);
    @(negedge Clock);
    Start = 1'b0;
    startTick = tickCount;
    checkOutput("start_busy", 32'(Busy), 32'd1);
    checkOutput("start_flags_clear", 32'({FalseStart, TimedOut}), 32'd0);
  endtask

  task automatic waitForW();
    bit found = 1'b0;
    int exp;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge Clock);
      if (w === 1'b1) found = 1'b1;
    end
    checkOutput("w_seen", 32'(found), 32'd1);
    exp = delayQ.pop_front();
    if (found) begin
      wTick = tickCount;
      checkOutput("w_delay_ticks", 32'(tickCount - startTick), 32'(exp));
      @(negedge Clock);
      checkOutput("w_width", 32'(w), 32'd0);
    end
  endtask

  task automatic pressButton(input logic [7:0] time_bcd, input logic [7:0] expBest, input logic expNew);
    best_exp_t e;
    {BCD1, BCD0} = time_bcd;
    @(negedge Clock);
    e.best = expBest;
    e.newBest = expNew;
    bestQ.push_back(e);
    Pushn = 1'b0;
    @(negedge Clock);
    Pushn = 1'b1;
  endtask

  task automatic waitIdle(input string tag);
    bit idle = 1'b0;
    best_exp_t e;
    for (int i = 0; i < 100 && !idle; i++) begin
      if (Busy === 1'b0) idle = 1'b1;
      else @(negedge Clock);
    end
    checkOutput({tag, "_idle"}, 32'(idle), 32'd1);
    e = bestQ.pop_front();
    checkOutput({tag, "_newbest"}, 32'(NewBest), 32'(e.newBest));
    checkOutput({tag, "_best"}, 32'({Best1, Best0}), 32'(e.best));
    @(negedge Clock);
    checkOutput({tag, "_newbest_drop"}, 32'(NewBest), 32'd0);
  endtask

  initial begin
    best_exp_t e;
    bit reached;

    #12;
    checkResetOutputs("reset");
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // False start three ticks into the wait.
    applyStimulus(1'b0, 0);
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (tickCount - startTick >= 3) reached = 1'b1;
      else @(negedge Clock);
    end
    Pushn = 1'b0;
    @(negedge Clock);
    Pushn = 1'b1;
    checkOutput("false_start_flag", 32'(FalseStart), 32'd1);
    checkOutput("false_start_busy", 32'(Busy), 32'd0);
    repeat (200) @(negedge Clock);
    checkOutput("false_start_no_w", 32'(wCount), 32'd0);
    checkOutput("false_start_best", 32'({Best1, Best0}), 32'h99);

    applyStimulus(1'b1, 0);
    waitForW();
    pressButton(8'h23, 8'h23, 1'b1);
    waitIdle("trial_23");

    applyStimulus(1'b1, 0);
    waitForW();
    pressButton(8'h31, 8'h23, 1'b0);
    waitIdle("trial_31");

    applyStimulus(1'b1, 0);
    waitForW();
    pressButton(8'h23, 8'h23, 1'b0);
    waitIdle("trial_equal");

    // No push at all after w: abandoned on the sixth tick.
    applyStimulus(1'b1, 0);
    waitForW();
    e.best = 8'h23;
    e.newBest = 1'b0;
    bestQ.push_back(e);
    waitIdle("timeout");
    checkOutput("timeout_flag", 32'(TimedOut), 32'd1);
    checkOutput("timeout_ticks", 32'(tickCount - wTick), 32'd6);

    // Asynchronous reset in the middle of TIMING.
    applyStimulus(1'b1, 0);
    waitForW();
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1 checkResetOutputs("mid_reset");
    @(negedge Clock);
    Reset = 1'b0;
    applyStimulus(1'b1, MIN_DELAY + 2 + 1);
    waitForW();
    pressButton(8'h45, 8'h45, 1'b1);
    waitIdle("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
